// File: rtl/mux_scan_ctrl.sv
// Sequences an external 8-to-1 mux through all channels, waiting SETTLE cycles
// after each select change before capturing the mux output into data[sel].
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] en_mask,
  input  logic       mux_o,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       data_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  localparam logic [2:0] CNT_LOAD  = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
  localparam bit         NO_SETTLE = (SETTLE == 0);

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sel        <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data       <= 8'd0;
      data_valid <= 1'b0;
      cnt        <= 3'd0;
      mask       <= 8'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sel        <= 3'd0;
            data       <= 8'd0;
            data_valid <= 1'b0;
            mask       <= en_mask;
            busy       <= 1'b1;
            cnt        <= CNT_LOAD;
            state      <= NO_SETTLE ? S_SAMPLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
            sel   <= 3'd0;
            busy  <= 1'b0;
            cnt   <= 3'd0;
          end else if (cnt == 3'd0) begin
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_SAMPLE: begin
          // Abort wins over the capture scheduled on this same edge.
          if (abort) begin
            state <= S_IDLE;
            sel   <= 3'd0;
            busy  <= 1'b0;
            cnt   <= 3'd0;
          end else begin
            data[sel] <= mux_o & mask[sel];
            if (sel == 3'd7) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              data_valid <= 1'b1;
            end else begin
              sel   <= sel + 3'd1;
              cnt   <= CNT_LOAD;
              state <= NO_SETTLE ? S_SAMPLE : S_WAIT;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          sel   <= 3'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Four scanners (SETTLE 0,1,2,7) share stimulus; each is checked every cycle
// against a timeline model plus table vectors and directed corner sequences.
module tb_mux_scan_ctrl;

  localparam int N = 4;
  localparam int SV[N] = '{0, 1, 2, 7};

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [7:0] en_mask, pat;
  logic [N-1:0]       mux_o, busy, done, data_valid;
  logic [N-1:0][2:0]  sel;
  logic [N-1:0][7:0]  data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign mux_o[g] = pat[sel[g]];
    mux_scan_ctrl #(.SETTLE((g == 3) ? 7 : g)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .en_mask(en_mask),
      .mux_o(mux_o[g]), .sel(sel[g]), .busy(busy[g]), .done(done[g]),
      .data(data[g]), .data_valid(data_valid[g])
    );
  end

  // Model: phase 0 idle, 1 scanning (t = cycles since accept), 2 done cycle.
  int         m_phase[N];
  int         m_t[N];
  logic [7:0] m_mask[N];
  logic [7:0] m_data[N];
  logic       m_dv[N];

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int per;
      per = SV[i] + 1;
      if (rst) begin
        m_phase[i] = 0; m_data[i] = 8'h00; m_dv[i] = 1'b0; m_mask[i] = 8'h00;
      end else if (m_phase[i] == 0) begin
        if (start) begin
          m_phase[i] = 1; m_t[i] = 0; m_mask[i] = en_mask;
          m_data[i] = 8'h00; m_dv[i] = 1'b0;
        end
      end else if (m_phase[i] == 1) begin
        if (abort) m_phase[i] = 0;
        else begin
          m_t[i]++;
          if (m_t[i] % per == 0) begin
            int c;
            c = m_t[i] / per - 1;
            m_data[i][c] = pat[c] & m_mask[i][c];
            if (c == 7) begin m_phase[i] = 2; m_dv[i] = 1'b1; end
          end
        end
      end else begin
        m_phase[i] = 0;
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < N; i++) begin
      logic [2:0] es;
      logic       eb, ed;
      int         q;
      q  = m_t[i] / (SV[i] + 1);
      es = (m_phase[i] == 1) ? 3'((q > 7) ? 7 : q) : (m_phase[i] == 2) ? 3'd7 : 3'd0;
      eb = (m_phase[i] == 1);
      ed = (m_phase[i] == 2);
      cmp($sformatf("model[S=%0d] {sel,busy,done,data,dv}", SV[i]),
          {19'd0, sel[i], busy[i], done[i], data[i], data_valid[i]},
          {19'd0, es, eb, ed, m_data[i], m_dv[i]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic run_scan(input int di, input logic [7:0] msk, input logic [7:0] p,
                          output logic [7:0] d, output logic dv, output int lat);
    en_mask = msk; pat = p; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      if (done[di]) begin lat = n; break; end
      tick();
    end
    d = data[di]; dv = data_valid[di];
    repeat (70) tick();
  endtask

  typedef struct {
    int         di;
    logic [7:0] mask;
    logic [7:0] pat;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] d;
    logic       dv;
    int         lat, seen;

    vecs[0] = '{1, 8'hFF, 8'hA5, 8'hA5, 16};
    vecs[1] = '{0, 8'h0F, 8'hFF, 8'h0F, 8};
    vecs[2] = '{2, 8'hF0, 8'h3C, 8'h30, 24};
    vecs[3] = '{3, 8'hFF, 8'h5A, 8'h5A, 64};
    vecs[4] = '{1, 8'h00, 8'hFF, 8'h00, 16};
    vecs[5] = '{0, 8'hAA, 8'hFF, 8'hAA, 8};

    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0; m_t[i] = 0; m_mask[i] = 0; m_data[i] = 0; m_dv[i] = 0;
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0; en_mask = 8'h00; pat = 8'h00;
    @(negedge clk);
    tick();
    tick();
    cmp("reset outputs", {busy, done, data_valid, data}, 44'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_scan(vecs[v].di, vecs[v].mask, vecs[v].pat, d, dv, lat);
      cmp($sformatf("vec%0d data", v), {24'd0, d}, {24'd0, vecs[v].exp_data});
      cmp($sformatf("vec%0d data_valid", v), {31'd0, dv}, 32'd1);
      cmp($sformatf("vec%0d done latency", v), lat, vecs[v].exp_lat);
    end

    // Abort at sel=3 on the SETTLE=2 scanner.
    en_mask = 8'hFF; pat = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 100 && sel[2] != 3'd3; n++) tick();
    cmp("abort reached sel=3", {29'd0, sel[2]}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmp("abort sel/busy/dv", {28'd0, sel[2], busy[2], data_valid[2]}, 32'd0);
    cmp("abort partial data", {24'd0, data[2]}, 32'h07);
    for (int n = 0; n < 80; n++) begin
      if (done[2]) seen++;
      tick();
    end
    cmp("abort no done", seen, 0);

    // start held through DONE on the SETTLE=1 scanner.
    en_mask = 8'hFF; pat = 8'hA5; start = 1'b1;
    tick();
    for (int n = 0; n < 40 && !done[1]; n++) tick();
    cmp("held start done", {31'd0, done[1]}, 32'd1);
    cmp("held start data", {24'd0, data[1]}, 32'hA5);
    tick();
    cmp("held start idle gap", {28'd0, busy[1], sel[1]}, 32'd0);
    cmp("held start data kept", {23'd0, data_valid[1], data[1]}, 32'h1A5);
    tick();
    cmp("held start re-accept", {23'd0, busy[1], data[1]}, 32'h100);
    start = 1'b0;
    repeat (80) tick();

    // Reset at sel=5 mid-scan, then a full scan.
    en_mask = 8'hFF; pat = 8'hC3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40 && sel[1] != 3'd5; n++) tick();
    cmp("rst reached sel=5", {29'd0, sel[1]}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("rst mid-scan outputs", {sel, busy, done, data_valid}, 24'd0);
    cmp("rst mid-scan data", data, 32'd0);
    run_scan(1, 8'hFF, 8'h3C, d, dv, lat);
    cmp("post-rst data", {24'd0, d}, 32'h3C);
    cmp("post-rst latency", lat, 16);

    // Random traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 7) == 0);
      abort   = ($urandom_range(0, 40) == 0);
      rst     = ($urandom_range(0, 200) == 0);
      en_mask = 8'($urandom);
      pat     = 8'($urandom);
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 1, range 0..7, the number of wait cycles after each select change before sampling.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request an 8-channel scan; acted on only in IDLE.
REQ-006 abort  input  1  cancel a scan in progress.
REQ-007 en_mask  input  8  channel enable, bit c enables channel c; latched when start is accepted.
REQ-008 mux_o  input  1  output of the downstream 8-to-1 mux for the channel currently on sel.
REQ-009 sel  output  3  select lines driven to the 8-to-1 mux.
REQ-010 busy  output  1  high while a scan is in progress (WAIT or SAMPLE state).
REQ-011 done  output  1  single-cycle pulse when a scan completes normally.
REQ-012 data  output  8  captured scan result, bit c is the value of channel c.
REQ-013 data_valid  output  1  high when data holds a complete, unaborted scan.

Function
REQ-014 The block SHALL implement the FSM states IDLE, WAIT, SAMPLE and DONE.
REQ-015 IDLE with start=1 SHALL accept the scan on that edge:
  - sel <= 0, data <= 0, data_valid <= 0, latch en_mask;
  - move to WAIT with the settle counter loaded to SETTLE-1 when SETTLE>0;
  - move directly to SAMPLE when SETTLE=0.
REQ-016 WAIT SHALL decrement the counter each cycle and move to SAMPLE on the edge where the counter is 0.
REQ-017 SAMPLE SHALL capture data[sel] <= mux_o AND latched_mask[sel] on one edge.
REQ-018 In SAMPLE with sel<7, the block SHALL increment sel and re-enter WAIT (reload the counter), or stay in SAMPLE when SETTLE=0.
REQ-019 In SAMPLE with sel=7, the block SHALL move to DONE with sel held at 7.
REQ-020 Each channel SHALL cost exactly SETTLE+1 cycles; masked channels SHALL keep this same timing and store 0.
REQ-021 If start is accepted at edge k, channel c SHALL be sampled at edge k+(c+1)*(SETTLE+1).
REQ-022 DONE SHALL last one cycle with done=1 and data_valid=1, then return to IDLE with sel <= 0.
REQ-023 data and data_valid SHALL hold their values in IDLE until the next accepted start.
REQ-024 busy SHALL be 1 exactly in WAIT and SAMPLE.
REQ-025 The block SHALL ignore start in WAIT, SAMPLE and DONE; it SHALL NOT queue or restart.
REQ-026 abort=1 in WAIT or SAMPLE SHALL cause IDLE on the next edge:
  - sel <= 0, data_valid stays 0, no done pulse;
  - data keeps any partially captured bits;
  - abort SHALL have priority over the same-edge sample.
REQ-027 The block SHALL ignore abort in IDLE and DONE.
REQ-028 abort and start both high in IDLE SHALL accept the start.
REQ-029 sel SHALL change only on clock edges and SHALL never exceed 7 (no wrap past 7 inside a scan).

Reset
REQ-030 rst=1 SHALL force on the next edge: state IDLE, sel=0, data=0, busy=0, done=0, data_valid=0, counter=0, latched mask=0.
REQ-031 rst SHALL have priority over start and abort.
REQ-032 Reset mid-scan SHALL discard the scan with no done pulse.
REQ-033 After rst is released, the first start SHALL be accepted on the first edge with rst=0 and start=1.

Verification
REQ-034 SETTLE=1, en_mask=FF, mux_o driven as bit sel of pattern A5, start at edge 0:
  - samples at edges 2,4,...,16;
  - done high only in cycle 16-17;
  - data=A5, data_valid=1.
REQ-035 SETTLE=0, en_mask=0F, mux_o=1 constantly:
  - sel steps 0..7 on consecutive edges;
  - done pulse after 8 samples;
  - data=0F.
REQ-036 SETTLE=2, abort asserted while sel=3:
  - IDLE next edge, sel=0;
  - no done, data_valid=0;
  - data bits 0..2 retain their captured values.
REQ-037 start held high during a whole scan and through DONE:
  - first scan completes normally;
  - a new scan is accepted only on the IDLE edge after DONE;
  - data is cleared to 00 on that acceptance.
REQ-038 rst pulsed at sel=5 mid-scan:
  - all outputs 0 the next edge, no done;
  - a following start produces a correct full scan.
REQ-039 SETTLE=7: per-channel spacing SHALL be 8 cycles, and done SHALL occur 64 cycles after start is accepted.
